// File: rtl/phy_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data physical bus arbiter:
// FSM state encoding, lane constants and TLB fault-decode helpers.
package phy_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } arb_state_t;

    // Fetches and loads always read the whole word.
    localparam logic [3:0] BE_FULL_WORD = 4'hF;

    // Width of the bus-ack watchdog counter.
    localparam int unsigned WD_WIDTH = 8;

    // A data access faults on a TLB miss, an invalid entry, or a store to a
    // page whose dirty bit is still clear.
    function automatic logic data_faults(input logic miss, input logic valid,
                                         input logic we, input logic dirty);
        return miss | ~valid | (we & ~dirty);
    endfunction

    // A fetch faults on a TLB miss or an invalid entry.
    function automatic logic inst_faults(input logic miss, input logic valid);
        return miss | ~valid;
    endfunction

    // The external bus is word addressed; byte offset bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/phy_bus_arbiter_watchdog.sv
// Counts consecutive cycles a bus request waits without an acknowledge and
// flags expiry on the LIMIT-th waiting cycle.
module bus_watchdog
    import phy_bus_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [WD_WIDTH-1:0] LAST_COUNT = WD_WIDTH'(LIMIT - 1);

    logic [WD_WIDTH-1:0] count;

    // Expiry is seen in the same cycle as the final waiting cycle so the
    // owner can drop its request at the next edge.
    assign expired = run && (count == LAST_COUNT);

    // Waiting-cycle counter; restarts on a new transaction or after expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/phy_bus_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one external
// bus. Data has priority. TLB faults complete locally without a bus cycle;
// a watchdog aborts bus cycles whose acknowledge never arrives.
//
// Handshake: a requester raises *_req (level) with its address/controls and
// holds them until it sees a one-cycle *_ack or *_fault pulse; it must then
// drop or renew the request. On the bus side bus_req and the bus address,
// data and lanes stay stable until the cycle in which bus_ack=1 is sampled;
// bus_ack is only honoured while a transaction is outstanding.
module phy_bus_arbiter
    import phy_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_req,
    input  logic [31:0] inst_addr_physic,
    input  logic        inst_miss,
    input  logic        inst_valid,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_byte_en,
    input  logic [31:0] data_wdata,
    input  logic [31:0] data_addr_physic,
    input  logic        data_miss,
    input  logic        data_valid,
    input  logic        data_dirty,
    output logic [31:0] inst_rdata,
    output logic [31:0] data_rdata,
    output logic        inst_ack,
    output logic        data_ack,
    output logic        inst_fault,
    output logic        data_fault,
    output logic        bus_error,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byte_en,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    arb_state_t state;

    logic data_bad;
    logic inst_bad;
    logic pulse_busy;
    logic accept_data;
    logic accept_inst;
    logic wd_clear;
    logic wd_run;
    logic wd_expired;

    // Request decode: data first, and nothing new while a completion pulse
    // from the previous transaction is still on the outputs.
    always_comb begin
        data_bad    = data_faults(data_miss, data_valid, data_we, data_dirty);
        inst_bad    = inst_faults(inst_miss, inst_valid);
        pulse_busy  = inst_ack | data_ack | inst_fault | data_fault;
        accept_data = data_req & ~pulse_busy;
        accept_inst = inst_req & ~data_req & ~pulse_busy;
        wd_clear    = (state == ST_IDLE) &
                      ((accept_data & ~data_bad) | (accept_inst & ~inst_bad));
        wd_run      = bus_req & ~bus_ack;
    end

    // A requester stalls until its own completion pulse is on the outputs.
    assign stall = (inst_req & ~(inst_ack | inst_fault)) |
                   (data_req & ~(data_ack | data_fault));

    bus_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .run    (wd_run),
        .expired(wd_expired)
    );

    // Arbiter FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            inst_rdata  <= '0;
            data_rdata  <= '0;
            inst_ack    <= 1'b0;
            data_ack    <= 1'b0;
            inst_fault  <= 1'b0;
            data_fault  <= 1'b0;
            bus_error   <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_byte_en <= '0;
        end else begin
            inst_ack   <= 1'b0;
            data_ack   <= 1'b0;
            inst_fault <= 1'b0;
            data_fault <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_data) begin
                        if (data_bad) begin
                            data_fault <= 1'b1;
                        end else begin
                            bus_req     <= 1'b1;
                            bus_we      <= data_we;
                            bus_addr    <= word_align(data_addr_physic);
                            bus_byte_en <= data_we ? data_byte_en : BE_FULL_WORD;
                            bus_wdata   <= data_we ? data_wdata : 32'h0;
                            state       <= ST_DATA;
                        end
                    end else if (accept_inst) begin
                        if (inst_bad) begin
                            inst_fault <= 1'b1;
                        end else begin
                            bus_req     <= 1'b1;
                            bus_we      <= 1'b0;
                            bus_addr    <= word_align(inst_addr_physic);
                            bus_byte_en <= BE_FULL_WORD;
                            bus_wdata   <= 32'h0;
                            state       <= ST_INST;
                        end
                    end
                end
                ST_DATA, ST_INST: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= ST_IDLE;
                        if (state == ST_DATA) begin
                            data_rdata <= bus_rdata;
                            data_ack   <= 1'b1;
                        end else begin
                            inst_rdata <= bus_rdata;
                            inst_ack   <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        bus_req   <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= ST_IDLE;
                        if (state == ST_DATA) begin
                            data_fault <= 1'b1;
                        end else begin
                            inst_fault <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_bus_arbiter.sv
// Directed bench for phy_bus_arbiter: drivers issue requests and push the
// expected completion event; a monitor pops and compares on every pulse.
module tb_phy_bus_arbiter;

    localparam logic [4:0] EV_DACK = 5'b00001;
    localparam logic [4:0] EV_IACK = 5'b00010;
    localparam logic [4:0] EV_DF   = 5'b00100;
    localparam logic [4:0] EV_IF   = 5'b01000;
    localparam logic [4:0] EV_TO   = 5'b10100;

    logic        clk;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr_physic;
    logic        inst_miss;
    logic        inst_valid;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_byte_en;
    logic [31:0] data_wdata;
    logic [31:0] data_addr_physic;
    logic        data_miss;
    logic        data_valid;
    logic        data_dirty;
    logic [31:0] inst_rdata;
    logic [31:0] data_rdata;
    logic        inst_ack;
    logic        data_ack;
    logic        inst_fault;
    logic        data_fault;
    logic        bus_error;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;
    int bus_req_cycles = 0;
    logic [36:0] exp_q[$];

    phy_bus_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_req        (inst_req),
        .inst_addr_physic(inst_addr_physic),
        .inst_miss       (inst_miss),
        .inst_valid      (inst_valid),
        .data_req        (data_req),
        .data_we         (data_we),
        .data_byte_en    (data_byte_en),
        .data_wdata      (data_wdata),
        .data_addr_physic(data_addr_physic),
        .data_miss       (data_miss),
        .data_valid      (data_valid),
        .data_dirty      (data_dirty),
        .inst_rdata      (inst_rdata),
        .data_rdata      (data_rdata),
        .inst_ack        (inst_ack),
        .data_ack        (data_ack),
        .inst_fault      (inst_fault),
        .data_fault      (data_fault),
        .bus_error       (bus_error),
        .stall           (stall),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_byte_en     (bus_byte_en),
        .bus_rdata       (bus_rdata),
        .bus_ack         (bus_ack)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] ev(input logic [4:0] flags, input logic [31:0] rdata);
        return {flags, rdata};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [36:0] obs;
        logic [36:0] e;
        if (bus_req) bus_req_cycles++;
        if (rst_n && (data_ack || inst_ack || data_fault || inst_fault || bus_error)) begin
            obs = {bus_error, inst_fault, data_fault, inst_ack, data_ack,
                   data_ack ? data_rdata : (inst_ack ? inst_rdata : 32'h0)};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %h expected none", obs);
            end else begin
                e = exp_q.pop_front();
                check("completion_event", 64'(obs), 64'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Waits for bus_req, checks the registered bus controls, then acks in the
    // ack_at-th cycle of bus_req. lat = cycles from request issue to bus_req.
    task automatic bus_cycle(input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input int ack_at,
                             input logic [31:0] rdata, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_req) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            check("bus_req_seen", 64'(0), 64'(1));
            return;
        end
        check("bus_addr", 64'(bus_addr), 64'(e_addr));
        check("bus_we", 64'(bus_we), 64'(e_we));
        check("bus_byte_en", 64'(bus_byte_en), 64'(e_be));
        if (e_we) check("bus_wdata", 64'(bus_wdata), 64'(e_wdata));
        for (int i = 1; i < ack_at; i++) begin
            @(posedge clk);
            #1;
        end
        check("bus_req_held", 64'(bus_req), 64'(1));
        check("bus_addr_held", 64'(bus_addr), 64'(e_addr));
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        @(posedge clk);
        #1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    // Waits for the chosen side's ack/fault, checking stall on the way, and
    // returns just after the next rising edge so the caller can drop req.
    task automatic wait_done(input bit is_data, input logic exp_stall_wait, input logic exp_stall_done);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_data ? (data_ack || data_fault) : (inst_ack || inst_fault)) begin
                seen = 1'b1;
                check("stall_at_done", 64'(stall), 64'(exp_stall_done));
                break;
            end
            check("stall_waiting", 64'(stall), 64'(exp_stall_wait));
        end
        if (!seen) check("done_seen", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        inst_req = 1'b0; inst_addr_physic = '0; inst_miss = 1'b0; inst_valid = 1'b1;
        data_req = 1'b0; data_we = 1'b0; data_byte_en = 4'h0; data_wdata = '0;
        data_addr_physic = '0; data_miss = 1'b0; data_valid = 1'b1; data_dirty = 1'b1;
        bus_ack = 1'b0; bus_rdata = '0;

        // Reset values
        idle(3);
        check("reset_bus_req", 64'(bus_req), 64'(0));
        check("reset_bus_addr", 64'(bus_addr), 64'(0));
        check("reset_rdata", {data_rdata, inst_rdata}, 64'(0));
        check("reset_pulses", 64'({inst_ack, data_ack, inst_fault, data_fault, bus_error}), 64'(0));
        check("reset_stall_idle", 64'(stall), 64'(0));

        // Load at 0x1004, queued during reset, accepted on first edge after release
        data_req = 1'b1; data_addr_physic = 32'h0000_1004;
        #1;
        check("reset_stall_req", 64'(stall), 64'(1));
        exp_q.push_back(ev(EV_DACK, 32'hDEAD_BEEF));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_cycle(32'h0000_1004, 1'b0, 4'hF, 32'h0, 3, 32'hDEAD_BEEF, lat);
        check("first_accept_latency", 64'(lat), 64'(1));
        wait_done(1'b1, 1'b1, 1'b0);
        data_req = 1'b0;
        check("load_rdata", 64'(data_rdata), 64'(32'hDEAD_BEEF));

        // Simultaneous data and inst: data served first
        idle(2);
        data_req = 1'b1; data_addr_physic = 32'h0000_0400;
        inst_req = 1'b1; inst_addr_physic = 32'h0000_0200;
        exp_q.push_back(ev(EV_DACK, 32'h1111_0400));
        exp_q.push_back(ev(EV_IACK, 32'h2222_0200));
        bus_cycle(32'h0000_0400, 1'b0, 4'hF, 32'h0, 2, 32'h1111_0400, lat);
        wait_done(1'b1, 1'b1, 1'b1);
        data_req = 1'b0;
        bus_cycle(32'h0000_0200, 1'b0, 4'hF, 32'h0, 1, 32'h2222_0200, lat);
        wait_done(1'b0, 1'b1, 1'b0);
        inst_req = 1'b0;
        check("inst_rdata", 64'(inst_rdata), 64'(32'h2222_0200));

        // Store to a dirty page, unaligned address, partial lanes
        idle(1);
        data_req = 1'b1; data_we = 1'b1; data_addr_physic = 32'h0000_2007;
        data_byte_en = 4'b0011; data_wdata = 32'hCAFE_F00D;
        exp_q.push_back(ev(EV_DACK, 32'h5555_AAAA));
        bus_cycle(32'h0000_2004, 1'b1, 4'b0011, 32'hCAFE_F00D, 2, 32'h5555_AAAA, lat);
        check("store_accept_latency", 64'(lat), 64'(1));
        wait_done(1'b1, 1'b1, 1'b0);
        data_req = 1'b0;

        // Store to a clean page faults, no bus cycle
        idle(1);
        bus_req_cycles = 0;
        data_dirty = 1'b0; data_req = 1'b1;
        exp_q.push_back(ev(EV_DF, 32'h0));
        wait_done(1'b1, 1'b1, 1'b0);
        data_req = 1'b0; data_dirty = 1'b1; data_we = 1'b0;
        idle(2);
        check("store_fault_no_bus", 64'(bus_req_cycles), 64'(0));

        // Fetch TLB miss
        inst_miss = 1'b1; inst_req = 1'b1; inst_addr_physic = 32'h0000_0300;
        exp_q.push_back(ev(EV_IF, 32'h0));
        wait_done(1'b0, 1'b1, 1'b0);
        inst_req = 1'b0; inst_miss = 1'b0;
        idle(2);
        check("inst_fault_no_bus", 64'(bus_req_cycles), 64'(0));

        // Load through an invalid entry
        data_valid = 1'b0; data_req = 1'b1; data_addr_physic = 32'h0000_3000;
        exp_q.push_back(ev(EV_DF, 32'h0));
        wait_done(1'b1, 1'b1, 1'b0);
        data_req = 1'b0; data_valid = 1'b1;
        idle(2);
        check("invalid_fault_no_bus", 64'(bus_req_cycles), 64'(0));
        check("rdata_hold_after_faults", 64'(data_rdata), 64'(32'h5555_AAAA));

        // Fetch whose requester drops req mid-transaction
        inst_req = 1'b1; inst_addr_physic = 32'h0000_0302;
        exp_q.push_back(ev(EV_IACK, 32'h3333_0300));
        @(posedge clk);
        #1;
        inst_req = 1'b0;
        bus_cycle(32'h0000_0300, 1'b0, 4'hF, 32'h0, 2, 32'h3333_0300, lat);
        wait_done(1'b0, 1'b0, 1'b0);

        // Bus never acks: watchdog expires after 4 cycles of bus_req
        idle(1);
        bus_req_cycles = 0;
        data_req = 1'b1; data_addr_physic = 32'h0000_0800;
        exp_q.push_back(ev(EV_TO, 32'h0));
        wait_done(1'b1, 1'b1, 1'b0);
        data_req = 1'b0;
        check("timeout_bus_req_cycles", 64'(bus_req_cycles), 64'(4));
        check("timeout_bus_req_low", 64'(bus_req), 64'(0));
        check("rdata_hold_after_timeout", 64'(data_rdata), 64'(32'h5555_AAAA));

        // Back in IDLE: a normal load still works
        idle(1);
        data_req = 1'b1; data_addr_physic = 32'h0000_000C;
        exp_q.push_back(ev(EV_DACK, 32'h0BAD_F00D));
        bus_cycle(32'h0000_000C, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_F00D, lat);
        wait_done(1'b1, 1'b1, 1'b0);
        data_req = 1'b0;

        // Reset mid-transaction, then a late bus_ack that must be ignored
        idle(1);
        data_req = 1'b1; data_addr_physic = 32'h0000_1000;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_req) begin
                lat = i;
                break;
            end
        end
        check("reset_test_bus_req_seen", 64'(lat >= 0), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_drops_bus_req", 64'(bus_req), 64'(0));
        check("reset_clears_bus_addr", 64'(bus_addr), 64'(0));
        check("reset_clears_data_rdata", 64'(data_rdata), 64'(0));
        check("reset_stall_follows_req", 64'(stall), 64'(1));
        data_req = 1'b0;
        bus_req_cycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        @(posedge clk);
        #1;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        idle(4);
        check("late_ack_no_capture", 64'(data_rdata), 64'(0));
        check("late_ack_no_bus", 64'(bus_req_cycles), 64'(0));

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_bus_arbiter.md
PHY_BUS_ARBITER -- requirements
Module: phy_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the bus-ack watchdog limit in cycles (1..255).
REQ-002 SHALL have ports, one per line:
  clk  in  1  system clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  inst_req  in  1  fetch request, level, held until inst_ack/inst_fault
  inst_addr_physic  in  32  fetch physical address from TLB
  inst_miss, inst_valid  in  1,1  TLB fetch lookup status
  data_req  in  1  load/store request, level, held until data_ack/data_fault
  data_we  in  1  1=store
  data_byte_en  in  4  store byte lanes
  data_wdata  in  32  store data
  data_addr_physic  in  32  data physical address from TLB
  data_miss, data_valid, data_dirty  in  1,1,1  TLB data lookup status
  inst_rdata, data_rdata  out  32,32  registered read data
  inst_ack, data_ack  out  1,1  one-cycle completion pulses
  inst_fault, data_fault  out  1,1  one-cycle TLB-fault pulses, no bus access
  bus_error  out  1  one-cycle pulse on watchdog expiry
  stall  out  1  pipeline stall
  bus_req, bus_we  out  1,1  external bus request/write
  bus_addr, bus_wdata  out  32,32  external address/data
  bus_byte_en  out  4  external lanes
  bus_rdata  in  32  external read data
  bus_ack  in  1  external completion, valid one cycle

Function
REQ-003 SHALL implement states IDLE, DATA, INST; encoding 2 bits.
REQ-004 SHALL treat a data request as faulting when data_miss=1, or data_valid=0, or (data_we=1 and data_dirty=0); inst faulting when inst_miss=1 or inst_valid=0.
REQ-005 In IDLE, data request SHALL have priority over inst request.
REQ-006 IDLE with faulting data_req SHALL pulse data_fault next cycle, stay IDLE, no bus_req; inst likewise with inst_fault, only when no data_req.
REQ-007 IDLE with non-faulting selected request SHALL register bus_addr (physical address, bits [1:0] forced 0), bus_we, bus_byte_en (4'hF for inst and data loads), bus_wdata, assert bus_req next cycle and enter DATA or INST.
REQ-008 bus_req and bus address/data SHALL hold stable until the cycle bus_ack=1 is sampled; bus_req deasserts the following cycle.
REQ-009 On bus_ack in DATA/INST SHALL capture bus_rdata into data_rdata/inst_rdata, pulse matching ack next cycle, return IDLE; rdata holds until next capture.
REQ-010 Watchdog SHALL count 8-bit cycles with bus_req high and no bus_ack; on reaching TIMEOUT_CYCLES SHALL drop bus_req, pulse bus_error and the faulting side's *_fault, return IDLE; counter clears on entry to DATA/INST.
REQ-011 bus_ack in IDLE SHALL be ignored.
REQ-012 stall SHALL be combinational: 1 when (inst_req or data_req) and the corresponding ack/fault is not asserted this cycle.
REQ-013 A new request SHALL be accepted no earlier than the cycle after ack/fault (one idle cycle between transactions minimum 0 bus cycles wasted beyond IDLE).
REQ-014 Requester dropping req mid-transaction SHALL NOT abort the bus cycle; the ack still pulses.

Reset
REQ-015 rst_n low SHALL immediately force state IDLE, watchdog 0, and all outputs 0 (rdata 32'h0, bus_* 0, pulses 0), including mid-transaction; stall still follows REQ-012.
REQ-016 First request SHALL be accepted on first rising edge after rst_n deasserts.

Structure
REQ-017 State encodings and fault-condition constants SHALL live in the shared CPU defines header used by mmu/.
REQ-018 Watchdog SHALL be a sub-module bus_watchdog (clk, rst_n, clear, run, expired).

Verification
REQ-019 Load: data_req, addr 32'h0000_1004, TLB ok; bus_ack after 3 cycles with 32'hDEAD_BEEF -> data_ack pulse, data_rdata=32'hDEAD_BEEF, bus_addr=32'h0000_1004.
REQ-020 Simultaneous inst_req (32'h0000_0200) and data_req (32'h0000_0400) -> data served first, then inst; both acks in order, stall high until each ack.
REQ-021 Store with data_dirty=0 -> data_fault one cycle later, bus_req never asserted.
REQ-022 inst_miss=1 -> inst_fault pulse, no bus activity; data_valid=0 load -> data_fault.
REQ-023 bus_ack withheld, TIMEOUT_CYCLES=4 -> bus_error and data_fault after 4 cycles of bus_req, return IDLE.
REQ-024 rst_n asserted while bus_req=1 -> bus_req=0 immediately; late bus_ack after reset produces no ack.
